id_ex_stage: RTL and testbench

//  ID->EX pipeline register downstream of the register file. Latches the decoded instruction,
//  the register-file read data and the immediate. Bypasses a same-cycle writeback into the

---
 rtl/pipe_pkg.sv | 26 ++
 rtl/hazard_unit.sv | 27 ++
 rtl/id_ex_stage.sv | 109 ++++++++++
 tb/tb_id_ex_stage.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control bundle layout, ALUOp encodings, bubble constant.
package pipe_pkg;

    localparam int unsigned CTRL_W = 9;

    // Bit positions inside the control bundle
    // {Branch,RegDst,ALUSrc,MemToReg,MemWrite,MemRead,RegWrite,ALUOp[1:0]}
    localparam int unsigned CTRL_ALUOP_LO = 0;
    localparam int unsigned CTRL_ALUOP_HI = 1;
    localparam int unsigned CTRL_REGWRITE = 2;
    localparam int unsigned CTRL_MEMREAD  = 3;
    localparam int unsigned CTRL_MEMWRITE = 4;
    localparam int unsigned CTRL_MEMTOREG = 5;
    localparam int unsigned CTRL_ALUSRC   = 6;
    localparam int unsigned CTRL_REGDST   = 7;
    localparam int unsigned CTRL_BRANCH   = 8;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_e;

    localparam logic [CTRL_W-1:0] BUBBLE_CTRL = '0;

endpackage

// File: rtl/hazard_unit.sv
// Combinational load-use detection and writeback bypass selection.
module hazard_unit #(
    parameter int unsigned REG_AW = 5
) (
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_write_reg,
    output logic              lu,
    output logic              byp1,
    output logic              byp2
);

    // r0 is never a real producer, so it never bypasses or hazards
    always_comb begin
        byp1 = wb_reg_write && (wb_write_reg != '0) && (wb_write_reg == id_rs);
        byp2 = wb_reg_write && (wb_write_reg != '0) && (wb_write_reg == id_rt);
        lu   = ex_valid && ex_mem_read && (ex_rt != '0) && id_valid &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with WB bypass, load-use bubble insertion and stall counter.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CTRL_W = pipe_pkg::CTRL_W,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_uses_rt,
    input  logic [DATA_W-1:0] id_data1,
    input  logic [DATA_W-1:0] id_data2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_write_reg,
    input  logic [DATA_W-1:0] wb_write_data,
    input  logic              flush,
    input  logic              ex_hold,
    output logic              stall,
    output logic              ex_valid,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_rd,
    output logic [DATA_W-1:0] ex_data1,
    output logic [DATA_W-1:0] ex_data2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              lu;
    logic              byp1;
    logic              byp2;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;

    hazard_unit #(
        .REG_AW(REG_AW)
    ) u_hazard (
        .ex_valid    (ex_valid),
        .ex_mem_read (ex_ctrl[CTRL_MEMREAD]),
        .ex_rt       (ex_rt),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .wb_reg_write(wb_reg_write),
        .wb_write_reg(wb_write_reg),
        .lu          (lu),
        .byp1        (byp1),
        .byp2        (byp2)
    );

    // Operand selection (bypass) and the IF/ID stall request
    always_comb begin
        op1   = byp1 ? wb_write_data : id_data1;
        op2   = byp2 ? wb_write_data : id_data2;
        stall = (lu || ex_hold) && !flush;
    end

    // EX register bank: flush > hold > load-use bubble > normal advance
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ex_valid <= 1'b0;
            ex_rs    <= '0;
            ex_rt    <= '0;
            ex_rd    <= '0;
            ex_data1 <= '0;
            ex_data2 <= '0;
            ex_imm   <= '0;
            ex_ctrl  <= '0;
        end else if (flush || (lu && !ex_hold)) begin
            ex_valid <= 1'b0;
            ex_rs    <= '0;
            ex_rt    <= '0;
            ex_rd    <= '0;
            ex_data1 <= '0;
            ex_data2 <= '0;
            ex_imm   <= '0;
            ex_ctrl  <= BUBBLE_CTRL;
        end else if (!ex_hold) begin
            ex_valid <= id_valid;
            ex_rs    <= id_rs;
            ex_rt    <= id_rt;
            ex_rd    <= id_rd;
            ex_data1 <= op1;
            ex_data2 <= op2;
            ex_imm   <= id_imm;
            ex_ctrl  <= id_valid ? id_ctrl : BUBBLE_CTRL;
        end
    end

    // Saturating count of cycles where a load-use bubble is actually inserted
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt <= '0;
        end else if (lu && !flush && !ex_hold && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed cases plus randomized traffic vs a model.
module tb_id_ex_stage;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 9;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          id_valid = 0, id_uses_rt = 0;
    logic [AW-1:0] id_rs = 0, id_rt = 0, id_rd = 0;
    logic [DW-1:0] id_data1 = 0, id_data2 = 0, id_imm = 0;
    logic [CW-1:0] id_ctrl = 0;
    logic          wb_reg_write = 0;
    logic [AW-1:0] wb_write_reg = 0;
    logic [DW-1:0] wb_write_data = 0;
    logic          flush = 0, ex_hold = 0;

    logic          stall, ex_valid;
    logic [AW-1:0] ex_rs, ex_rt, ex_rd;
    logic [DW-1:0] ex_data1, ex_data2, ex_imm;
    logic [CW-1:0] ex_ctrl;
    logic [15:0]   stall_cnt;

    logic          stall_b, ex_valid_b;
    logic [AW-1:0] ex_rs_b, ex_rt_b, ex_rd_b;
    logic [DW-1:0] ex_data1_b, ex_data2_b, ex_imm_b;
    logic [CW-1:0] ex_ctrl_b;
    logic [1:0]    stall_cnt_b;

    int total = 0;
    int bad = 0;

    // control bundle bits
    localparam logic [CW-1:0] C_RW  = 9'h004;
    localparam logic [CW-1:0] C_MR  = 9'h008;
    localparam logic [CW-1:0] C_SRC = 9'h040;
    localparam logic [CW-1:0] C_DST = 9'h080;

    id_ex_stage #(.DATA_W(DW), .REG_AW(AW), .CTRL_W(CW), .CNT_W(16)) dut (
        .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_uses_rt(id_uses_rt), .id_data1(id_data1), .id_data2(id_data2),
        .id_imm(id_imm), .id_ctrl(id_ctrl), .wb_reg_write(wb_reg_write),
        .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data), .flush(flush),
        .ex_hold(ex_hold), .stall(stall), .ex_valid(ex_valid), .ex_rs(ex_rs),
        .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_data1(ex_data1), .ex_data2(ex_data2),
        .ex_imm(ex_imm), .ex_ctrl(ex_ctrl), .stall_cnt(stall_cnt));

    id_ex_stage #(.DATA_W(DW), .REG_AW(AW), .CTRL_W(CW), .CNT_W(2)) dut_sat (
        .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_uses_rt(id_uses_rt), .id_data1(id_data1), .id_data2(id_data2),
        .id_imm(id_imm), .id_ctrl(id_ctrl), .wb_reg_write(wb_reg_write),
        .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data), .flush(flush),
        .ex_hold(ex_hold), .stall(stall_b), .ex_valid(ex_valid_b), .ex_rs(ex_rs_b),
        .ex_rt(ex_rt_b), .ex_rd(ex_rd_b), .ex_data1(ex_data1_b), .ex_data2(ex_data2_b),
        .ex_imm(ex_imm_b), .ex_ctrl(ex_ctrl_b), .stall_cnt(stall_cnt_b));

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct {
        logic          valid;
        logic [AW-1:0] rs, rt, rd;
        logic [DW-1:0] d1, d2, imm;
        logic [CW-1:0] ctrl;
    } instr_t;

    instr_t m_ex;
    int     m_cnt16;
    int     m_cnt2;

    function automatic instr_t empty_instr();
        instr_t b;
        b.valid = 0; b.rs = 0; b.rt = 0; b.rd = 0;
        b.d1 = 0; b.d2 = 0; b.imm = 0; b.ctrl = 0;
        return b;
    endfunction

    // does the instruction in ID need the value the load in EX has not fetched yet?
    function automatic bit model_lu();
        if (!m_ex.valid || !m_ex.ctrl[3] || m_ex.rt == 0 || !id_valid) return 0;
        if (m_ex.rt == id_rs) return 1;
        return id_uses_rt && (m_ex.rt == id_rt);
    endfunction

    // register read value as the regfile would return it after this cycle's writeback
    function automatic logic [DW-1:0] read_val(logic [AW-1:0] idx, logic [DW-1:0] rf);
        if (wb_reg_write && wb_write_reg != 0 && wb_write_reg == idx) return wb_write_data;
        return rf;
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_ex = empty_instr();
            m_cnt16 = 0;
            m_cnt2 = 0;
        end else begin
            bit hz;
            hz = model_lu();
            if (hz && !flush && !ex_hold) begin
                if (m_cnt16 < 65535) m_cnt16++;
                if (m_cnt2 < 3) m_cnt2++;
            end
            if (flush) m_ex = empty_instr();
            else if (ex_hold) ;
            else if (hz) m_ex = empty_instr();
            else begin
                m_ex.valid = id_valid;
                m_ex.rs = id_rs; m_ex.rt = id_rt; m_ex.rd = id_rd;
                m_ex.d1 = read_val(id_rs, id_data1);
                m_ex.d2 = read_val(id_rt, id_data2);
                m_ex.imm = id_imm;
                m_ex.ctrl = id_valid ? id_ctrl : '0;
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        logic [120:0] exp_v, got_a, got_b;
        bit exp_stall;
        exp_v = {m_ex.valid, m_ex.rs, m_ex.rt, m_ex.rd, m_ex.d1, m_ex.d2, m_ex.imm, m_ex.ctrl};
        got_a = {ex_valid, ex_rs, ex_rt, ex_rd, ex_data1, ex_data2, ex_imm, ex_ctrl};
        got_b = {ex_valid_b, ex_rs_b, ex_rt_b, ex_rd_b, ex_data1_b, ex_data2_b, ex_imm_b, ex_ctrl_b};
        exp_stall = (model_lu() || ex_hold) && !flush;
        total += 5;
        if (got_a !== exp_v) begin bad++; $display("FAIL cyc_ex t=%0t got=%h exp=%h", $time, got_a, exp_v); end
        if (got_b !== exp_v) begin bad++; $display("FAIL cyc_ex_sat t=%0t got=%h exp=%h", $time, got_b, exp_v); end
        if (stall !== exp_stall || stall_b !== exp_stall) begin
            bad++; $display("FAIL cyc_stall t=%0t got=%b/%b exp=%b", $time, stall, stall_b, exp_stall);
        end
        if (stall_cnt !== 16'(m_cnt16)) begin bad++; $display("FAIL cyc_cnt t=%0t got=%0d exp=%0d", $time, stall_cnt, m_cnt16); end
        if (stall_cnt_b !== 2'(m_cnt2)) begin bad++; $display("FAIL cyc_cnt2 t=%0t got=%0d exp=%0d", $time, stall_cnt_b, m_cnt2); end
    end

    // ---------------- directed helpers ----------------
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_id(input logic v, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                          input logic [AW-1:0] rd, input logic urt, input logic [DW-1:0] d1,
                          input logic [DW-1:0] d2, input logic [DW-1:0] imm, input logic [CW-1:0] c);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_uses_rt = urt;
        id_data1 = d1; id_data2 = d2; id_imm = imm; id_ctrl = c;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2 rstn = 1'b1;

        // pass-through
        set_id(1, 3, 4, 6, 1, 32'h11, 32'h22, 32'hFFFF_FFF0, C_RW);
        step();
        check("pass_data1", ex_data1, 32'h11);
        check("pass_imm", ex_imm, 32'hFFFF_FFF0);
        check("pass_valid", ex_valid, 1);

        // bypass from WB, then r0 never bypasses
        set_id(1, 5, 4, 6, 1, 0, 32'h22, 0, C_RW);
        wb_reg_write = 1; wb_write_reg = 5; wb_write_data = 32'hCAFE;
        step();
        check("byp_data1", ex_data1, 32'hCAFE);
        id_rs = 0; wb_write_reg = 0;
        step();
        check("byp_r0", ex_data1, 0);
        wb_reg_write = 0;

        // load-use on rs: one stall, one bubble, then the consumer enters
        set_id(1, 1, 7, 0, 0, 0, 0, 4, C_MR | C_RW | C_SRC);
        step();
        set_id(1, 7, 2, 3, 1, 32'h7, 32'h2, 0, C_RW | C_DST);
        #1 check("lu_stall", stall, 1);
        step();
        check("lu_bubble_valid", ex_valid, 0);
        check("lu_bubble_ctrl", ex_ctrl, 0);
        check("lu_cnt", stall_cnt, 1);
        check("lu_stall_drop", stall, 0);
        step();
        check("lu_consumer_in", {ex_valid, ex_rs}, {1'b1, 5'd7});

        // rt match but rt not a source: no hazard
        set_id(1, 1, 7, 0, 0, 0, 0, 4, C_MR | C_RW | C_SRC);
        step();
        set_id(1, 2, 7, 3, 0, 0, 0, 0, C_RW);
        #1 check("nouse_rt_stall", stall, 0);
        step();
        check("nouse_rt_in", {ex_valid, ex_rt}, {1'b1, 5'd7});

        // flush beats hold
        flush = 1; ex_hold = 1;
        #1 check("flush_hold_stall", stall, 0);
        step();
        check("flush_hold_valid", ex_valid, 0);
        flush = 0; ex_hold = 0;

        // hold for three cycles while ID changes
        set_id(1, 9, 10, 11, 1, 32'h1234, 32'h5678, 32'h9, C_RW);
        step();
        set_id(1, 12, 13, 14, 1, 32'hDEAD, 32'hBEEF, 32'h1, C_MR);
        ex_hold = 1;
        for (int i = 0; i < 3; i++) begin
            #1 check("hold_stall", stall, 1);
            step();
            check("hold_data1", ex_data1, 32'h1234);
        end
        ex_hold = 0;

        // five more load-use stalls: 2-bit counter saturates at 3
        for (int i = 0; i < 5; i++) begin
            set_id(1, 1, 7, 0, 0, 0, 0, 4, C_MR | C_RW);
            step();
            set_id(1, 7, 2, 3, 1, 0, 0, 0, C_RW);
            step();
        end
        check("sat_cnt2", stall_cnt_b, 3);
        check("sat_cnt16", stall_cnt, 6);

        // randomized traffic; the compare process does the checking
        for (int n = 0; n < 3000; n++) begin
            logic [CW-1:0] c;
            c = CW'($urandom);
            if ($urandom_range(0, 2) == 0) c[3] = 1'b1;
            set_id($urandom_range(0, 9) < 8, AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                   AW'($urandom), 1'($urandom), $urandom, $urandom, $urandom, c);
            wb_reg_write  = 1'($urandom);
            wb_write_reg  = AW'($urandom_range(0, 7));
            wb_write_data = $urandom;
            flush   = ($urandom_range(0, 9) == 0);
            ex_hold = ($urandom_range(0, 6) == 0);
            if (n == 1500) begin
                // asynchronous reset with a live instruction in EX
                set_id(1, 3, 4, 5, 0, 32'h55, 32'h66, 32'h77, C_RW);
                flush = 0; ex_hold = 0;
                step();
                check("rst_pre_valid", ex_valid, 1);
                #1 rstn = 1'b0;
                #1;
                check("rst_valid", ex_valid, 0);
                check("rst_fields", {ex_rs, ex_rt, ex_rd, ex_ctrl, ex_data1[31:0]}, 0);
                check("rst_data", {ex_data2, ex_imm}, 0);
                check("rst_cnt", {stall_cnt, stall_cnt_b}, 0);
                @(posedge clk);
                #2 rstn = 1'b1;
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
